sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous single-clock FIFO with write acknowledge, overflow/underflow error pulses and full/almost-full/empty/almost-empty status flags. The bench's interface-level monitor samples every one of its ports on the falling clock edge. It feeds the scoreboard and coverage collectors, and it is the design block the stimulus generator drives.

## Interface
- FIFO_WIDTH, 16, data word width in bits
- FIFO_DEPTH, 8, number of storage entries; any value ≥ 2, power of two not required
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_in  input  FIFO_WIDTH  write data
- data_out  output  FIFO_WIDTH  registered read data
- wr_ack  output  1  registered; write accepted in previous cycle
- overflow  output  1  registered; write rejected in previous cycle
- underflow  output  1  registered; read rejected in previous cycle
- full  output  1  combinational; count == FIFO_DEPTH
- almostfull  output  1  combinational; count == FIFO_DEPTH-1
- empty  output  1  combinational; count == 0
- almostempty  output  1  combinational; count == 1

## Operation
- State: memory [FIFO_DEPTH] × FIFO_WIDTH, wr_ptr and rd_ptr of width max(1,$clog2(FIFO_DEPTH)), count of width $clog2(FIFO_DEPTH)+1.
- Pointers increment modulo FIFO_DEPTH: value FIFO_DEPTH-1 wraps to 0.
- Accepted write (wr_en && !full): mem[wr_ptr] <= data_in; wr_ptr advances; wr_ack <= 1.
- Rejected write (wr_en && full): memory and wr_ptr unchanged; overflow <= 1.
- Accepted read (rd_en && !empty): data_out <= mem[rd_ptr]; rd_ptr advances.
- Rejected read (rd_en && empty): data_out holds; underflow <= 1.
- wr_ack, overflow and underflow are each 0 in any cycle without the triggering condition. They are one-cycle pulses per request cycle.
- The count update uses the pre-edge flags:
  - +1 on accepted write only
  - −1 on accepted read only
  - unchanged when both accepted or neither
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both are performed; count unchanged.
  - Full: read performed, write rejected, overflow=1; count decrements to FIFO_DEPTH-1.
  - Empty: write performed, read rejected, underflow=1, wr_ack=1; count becomes 1.
- data_out holds its last read value when no read is accepted.

## Timing
- Reset (asynchronous assert, released synchronously by the bench):
  - wr_ptr, rd_ptr, count = 0
  - data_out = 0
  - wr_ack, overflow, underflow = 0
  - empty = 1; full, almostfull, almostempty = 0
  - Memory contents are not reset.
- Reset asserted mid-operation clears all of the above immediately, regardless of clk. Stored data is discarded logically.
- Read latency: data_out is valid after the rising edge on which the read is accepted. The monitor sees it on the following falling edge.
- Write-to-read: a word written at edge k deasserts empty after edge k. That word is readable by a request presented for edge k+1.
- Status flags change only as a result of count changes, so they settle right after the rising edge.
- wr_ack, overflow and underflow describe the request sampled at the preceding rising edge.

## Configuration
- SYNC_FIFO_SVA_EN defined: the module compiles internal concurrent assertions, clocked on clk and disabled when !rst_n:
  - count never exceeds FIFO_DEPTH
  - full and empty are never both 1
  - overflow implies full in the prior cycle
  - underflow implies empty in the prior cycle
  - wr_ack and overflow are never both 1
- It also compiles cover properties for full, empty, and pointer wrap-around.
- Not defined: no assertions or covers are compiled. Functional behaviour is identical in both cases.

## Test plan
- Reset then idle → empty=1, full=0, data_out=0, wr_ack=overflow=underflow=0.
- Eight writes of 0x1111..0x8888, wr_ack=1 each → after the 7th write almostfull=1; after the 8th full=1. A ninth write of 0x9999 → overflow=1, wr_ack=0, memory unchanged.
- Eight reads after fill → data_out = 0x1111..0x8888 in order; almostempty=1 before the last read; empty=1 after it. A ninth read → underflow=1, data_out stays 0x8888.
- Full FIFO with wr_en=rd_en=1 and data_in=0xAAAA → data_out=0x1111, overflow=1, count=7. Empty FIFO with both high and data_in=0x5555 → underflow=1, wr_ack=1, count=1.
- Fill 5, read 5, then repeat 3 times with distinct data → pointers wrap and data order is preserved (checks non-power-of-2 wrap when FIFO_DEPTH=6).
- rst_n asserted low mid-cycle with count=4 → empty=1 immediately. A following write of 0x1234 and a read return 0x1234.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo.
// master drives requests, slave is the FIFO side.
interface sync_fifo_if #(
  parameter int FIFO_WIDTH = 16
) ();
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow,
    input  underflow, full, almostfull,
    input  empty, almostempty
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow,
    output underflow, full, almostfull,
    output empty, almostempty
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with ack/overflow/underflow pulses and status flags.
// Define SYNC_FIFO_SVA_EN to compile internal assertions and covers.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  sync_fifo_if.slave  bus
);
  localparam int PW =
    ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEP  = CW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full, empty, wr_ok, rd_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == DEP);
  assign empty = (count_q == '0);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = wr_ok;
    ovf_d    = bus.wr_en && full;
    udf_d    = bus.rd_en && empty;
    if (wr_ok) wr_ptr_d = nxt(wr_ptr_q);
    if (rd_ok) begin
      rd_ptr_d = nxt(rd_ptr_q);
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case (1'b1)
      (wr_ok && !rd_ok): count_d = count_q + CW'(1);
      (rd_ok && !wr_ok): count_d = count_q - CW'(1);
      default:           count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out    = dout_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q == DEP - CW'(1));
  assign bus.almostempty = (count_q == CW'(1));

`ifdef SYNC_FIFO_SVA_EN
  a_cnt: assert property (@(posedge clk)
    disable iff (!rst_n) count_q <= DEP);
  a_fe: assert property (@(posedge clk)
    disable iff (!rst_n) !(full && empty));
  a_ovf: assert property (@(posedge clk)
    disable iff (!rst_n) ovf_q |-> $past(full));
  a_udf: assert property (@(posedge clk)
    disable iff (!rst_n) udf_q |-> $past(empty));
  a_ack: assert property (@(posedge clk)
    disable iff (!rst_n) !(wr_ack_q && ovf_q));
  c_full: cover property (@(posedge clk)
    disable iff (!rst_n) full);
  c_empty: cover property (@(posedge clk)
    disable iff (!rst_n) empty);
  c_wwrap: cover property (@(posedge clk)
    disable iff (!rst_n) wr_ok && wr_ptr_q == LAST);
  c_rwrap: cover property (@(posedge clk)
    disable iff (!rst_n) rd_ok && rd_ptr_q == LAST);
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo, depth 8, width 16.
// Inputs change and outputs are checked on the falling edge.
module tb_sync_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sync_fifo_if #(.FIFO_WIDTH(16)) bus ();

  sync_fifo #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic        w,
    input logic        r,
    input logic [15:0] d
  );
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0);

    chk("rst_empty", 16'(bus.empty), 16'd1);
    chk("rst_full", 16'(bus.full), 16'd0);
    chk("rst_afull", 16'(bus.almostfull), 16'd0);
    chk("rst_aempty", 16'(bus.almostempty), 16'd0);
    chk("rst_dout", bus.data_out, 16'h0000);
    chk("rst_ack", 16'(bus.wr_ack), 16'd0);
    chk("rst_ovf", 16'(bus.overflow), 16'd0);
    chk("rst_udf", 16'(bus.underflow), 16'd0);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 16'(16'h1111 * i));
      chk("fill_ack", 16'(bus.wr_ack), 16'd1);
      chk("fill_afull", 16'(bus.almostfull),
          (i == 7) ? 16'd1 : 16'd0);
      chk("fill_full", 16'(bus.full),
          (i == 8) ? 16'd1 : 16'd0);
    end
    step(1'b1, 1'b0, 16'h9999);
    chk("ovf_pulse", 16'(bus.overflow), 16'd1);
    chk("ovf_ack", 16'(bus.wr_ack), 16'd0);
    chk("ovf_full", 16'(bus.full), 16'd1);
    step(1'b0, 1'b0, 16'h0);
    chk("ovf_clear", 16'(bus.overflow), 16'd0);

    for (int i = 1; i <= 8; i++) begin
      if (i == 8)
        chk("pre_aempty", 16'(bus.almostempty), 16'd1);
      step(1'b0, 1'b1, 16'h0);
      chk("drain_dout", bus.data_out, 16'(16'h1111 * i));
    end
    chk("drain_empty", 16'(bus.empty), 16'd1);
    step(1'b0, 1'b1, 16'h0);
    chk("udf_pulse", 16'(bus.underflow), 16'd1);
    chk("udf_hold", bus.data_out, 16'h8888);
    step(1'b0, 1'b0, 16'h0);
    chk("udf_clear", 16'(bus.underflow), 16'd0);

    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b0, 16'(16'h1111 * i));
    chk("refill_full", 16'(bus.full), 16'd1);
    step(1'b1, 1'b1, 16'hAAAA);
    chk("fboth_dout", bus.data_out, 16'h1111);
    chk("fboth_ovf", 16'(bus.overflow), 16'd1);
    chk("fboth_ack", 16'(bus.wr_ack), 16'd0);
    chk("fboth_cnt7", 16'(bus.almostfull), 16'd1);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("fboth_rd", bus.data_out, 16'(16'h1111 * i));
    end
    chk("fboth_empty", 16'(bus.empty), 16'd1);

    step(1'b1, 1'b1, 16'h5555);
    chk("eboth_udf", 16'(bus.underflow), 16'd1);
    chk("eboth_ack", 16'(bus.wr_ack), 16'd1);
    chk("eboth_cnt1", 16'(bus.almostempty), 16'd1);
    chk("eboth_hold", bus.data_out, 16'h8888);
    step(1'b0, 1'b1, 16'h0);
    chk("eboth_rd", bus.data_out, 16'h5555);
    chk("eboth_empty", 16'(bus.empty), 16'd1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        v = 16'hC000 + 16'(r * 16) + 16'(i);
        step(1'b1, 1'b0, v);
      end
      for (int i = 0; i < 5; i++) begin
        v = 16'hC000 + 16'(r * 16) + 16'(i);
        step(1'b0, 1'b1, 16'h0);
        chk("wrap_rd", bus.data_out, v);
      end
      chk("wrap_empty", 16'(bus.empty), 16'd1);
    end

    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 16'(16'h0F00 + i));
    chk("pre_rst_empty", 16'(bus.empty), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", 16'(bus.empty), 16'd1);
    chk("arst_dout", bus.data_out, 16'h0000);
    chk("arst_ack", 16'(bus.wr_ack), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h1234);
    chk("post_ack", 16'(bus.wr_ack), 16'd1);
    chk("post_aempty", 16'(bus.almostempty), 16'd1);
    step(1'b0, 1'b1, 16'h0);
    chk("post_rd", bus.data_out, 16'h1234);
    chk("post_empty", 16'(bus.empty), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
